// File: rtl/aes_round_seq_if.sv
// Block-level valid/ready handshake between the AES round sequencer and its
// upstream (plaintext/key) and downstream (ciphertext) buffers.
interface aes_round_seq_if;
    logic in_valid;
    logic in_ready;
    logic out_valid;
    logic out_ready;

    modport master (
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_valid
    );

    modport slave (
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_valid
    );
endinterface

// File: rtl/aes_round_seq.sv
// Control sequencer for an iterative AES encryption core: one round per clock,
// generating round count, Rcon and datapath enables, framed by valid/ready.
module aes_round_seq #(
    parameter int unsigned NR = 10
) (
    input  logic              clk,
    input  logic              rst,
    aes_round_seq_if.slave    hs,
    output logic              ld_init,
    output logic              st_en,
    output logic              key_en,
    output logic              mix_en,
    output logic [7:0]        rcon,
    output logic [3:0]        round_cnt,
    output logic              busy
);

    typedef enum logic [1:0] {StIdle, StRound, StLast, StHold} state_t;

    localparam logic [3:0] PreLast = 4'(NR - 1);

    state_t     state_q;
    logic       in_ready_q;
    logic       out_valid_q;
    logic       st_en_q;
    logic       mix_en_q;
    logic       busy_q;
    logic [7:0] rcon_q;
    logic [3:0] round_q;

    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
    endfunction

    // All outputs except ld_init are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            st_en_q     <= 1'b0;
            mix_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            rcon_q      <= 8'h01;
            round_q     <= 4'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (hs.in_valid) begin
                        state_q    <= StRound;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        st_en_q    <= 1'b1;
                        mix_en_q   <= 1'b1;
                        round_q    <= 4'd1;
                        rcon_q     <= 8'h01;
                    end
                end
                StRound: begin
                    round_q <= round_q + 4'd1;
                    rcon_q  <= xtime(rcon_q);
                    if (round_q == PreLast) begin
                        state_q  <= StLast;
                        mix_en_q <= 1'b0;
                    end
                end
                StLast: begin
                    state_q     <= StHold;
                    st_en_q     <= 1'b0;
                    out_valid_q <= 1'b1;
                end
                StHold: begin
                    if (hs.out_ready) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        round_q     <= 4'd0;
                        rcon_q      <= 8'h01;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign hs.in_ready  = in_ready_q;
    assign hs.out_valid = out_valid_q;
    assign ld_init      = hs.in_valid & in_ready_q;
    assign st_en        = st_en_q;
    assign key_en       = st_en_q;
    assign mix_en       = mix_en_q;
    assign rcon         = rcon_q;
    assign round_cnt    = round_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_aes_round_seq.sv
// Directed bench for aes_round_seq: control timing for NR=10 and NR=14, plus a
// bench-side AES-128 round datapath driven by the sequencer's enables.
module tb_aes_round_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes_round_seq_if hs();
    aes_round_seq_if hs14();

    logic       ld_init, st_en, key_en, mix_en, busy;
    logic [7:0] rcon;
    logic [3:0] round_cnt;
    logic       ld_init14, st_en14, key_en14, mix_en14, busy14;
    logic [7:0] rcon14;
    logic [3:0] round_cnt14;

    aes_round_seq #(.NR(10)) dut (
        .clk(clk), .rst(rst), .hs(hs),
        .ld_init(ld_init), .st_en(st_en), .key_en(key_en), .mix_en(mix_en),
        .rcon(rcon), .round_cnt(round_cnt), .busy(busy)
    );

    aes_round_seq #(.NR(14)) dut14 (
        .clk(clk), .rst(rst), .hs(hs14),
        .ld_init(ld_init14), .st_en(st_en14), .key_en(key_en14), .mix_en(mix_en14),
        .rcon(rcon14), .round_cnt(round_cnt14), .busy(busy14)
    );

    // {in_ready, out_valid, ld_init, st_en, key_en, mix_en, busy, round_cnt, rcon}
    wire [18:0] obs = {hs.in_ready, hs.out_valid, ld_init, st_en, key_en, mix_en, busy,
                       round_cnt, rcon};
    wire [18:0] obs14 = {hs14.in_ready, hs14.out_valid, ld_init14, st_en14, key_en14,
                         mix_en14, busy14, round_cnt14, rcon14};

    int total = 0;
    int bad   = 0;

    logic [7:0]   rc_tab [1:14];
    logic [127:0] pt, key, m_st, m_key;
    localparam logic [127:0] Cipher = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    // ---------------- bench-side AES-128 datapath ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [15:0] t = {b, b} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[8*(15-(r+4*c)) +: 8] = sbox(s[8*(15-(r+4*((c+r)%4))) +: 8]);
        return o;
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[8*(15-4*c) +: 8];
            a1 = s[8*(14-4*c) +: 8];
            a2 = s[8*(13-4*c) +: 8];
            a3 = s[8*(12-4*c) +: 8];
            o[8*(15-4*c) +: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
            o[8*(14-4*c) +: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
            o[8*(13-4*c) +: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
            o[8*(12-4*c) +: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
        return o;
    endfunction

    function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0 = k[127:96], w1 = k[95:64], w2 = k[63:32], w3 = k[31:0];
        logic [31:0] rw = {w3[23:0], w3[31:24]};
        logic [31:0] t  = {sbox(rw[31:24]) ^ rc, sbox(rw[23:16]), sbox(rw[15:8]),
                           sbox(rw[7:0])};
        logic [31:0] n0 = w0 ^ t;
        logic [31:0] n1 = w1 ^ n0;
        logic [31:0] n2 = w2 ^ n1;
        return {n0, n1, n2, w3 ^ n2};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic mix);
        logic [127:0] t = sub_shift(s);
        if (mix) t = mix_cols(t);
        return t ^ k;
    endfunction

    always @(posedge clk) begin
        if (ld_init) begin
            m_st  <= pt ^ key;
            m_key <= key;
        end else if (st_en) begin
            m_st  <= aes_round(m_st, key_step(m_key, rcon), mix_en);
            m_key <= key_step(m_key, rcon);
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (obs !== {7'b1000000, 4'd0, 8'h01}) begin
            bad++; $display("FAIL reset_nr10 got=%h want=%h", obs, {7'b1000000, 4'd0, 8'h01});
        end
        total++;
        if (obs14 !== {7'b1000000, 4'd0, 8'h01}) begin
            bad++; $display("FAIL reset_nr14 got=%h want=%h", obs14, {7'b1000000, 4'd0, 8'h01});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_spurious_idle;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            hs.in_valid = 1'b0; hs.out_ready = 1'b1;
            #1;
            total++;
            if (obs !== {7'b1000000, 4'd0, 8'h01}) begin
                bad++; $display("FAIL idle_out_ready c%0d got=%h want=%h", k, obs,
                                {7'b1000000, 4'd0, 8'h01});
            end
        end
    endtask

    task automatic test_single;
        logic [18:0] exp;
        pt  = 128'h00112233445566778899aabbccddeeff;
        key = 128'h000102030405060708090a0b0c0d0e0f;
        @(negedge clk);
        hs.in_valid = 1'b1; hs.out_ready = 1'b1;
        #1;
        total++;
        if (obs !== {7'b1010000, 4'd0, 8'h01}) begin
            bad++; $display("FAIL single_accept got=%h want=%h", obs, {7'b1010000, 4'd0, 8'h01});
        end
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            hs.in_valid = 1'b0;
            #1;
            if (k <= 9)       exp = {7'b0001111, 4'(k), rc_tab[k]};
            else if (k == 10) exp = {7'b0001101, 4'd10, 8'h36};
            else if (k == 11) exp = {7'b0100001, 4'd10, 8'h36};
            else              exp = {7'b1000000, 4'd0, 8'h01};
            total++;
            if (obs !== exp) begin
                bad++; $display("FAIL single_cycle%0d got=%h want=%h", k, obs, exp);
            end
            if (k == 11) begin
                total++;
                if (m_st !== Cipher) begin
                    bad++; $display("FAIL fips197_cipher got=%h want=%h", m_st, Cipher);
                end
            end
        end
    endtask

    task automatic test_backpressure;
        @(negedge clk);
        hs.in_valid = 1'b1; hs.out_ready = 1'b0;
        #1;
        total++;
        if (ld_init !== 1'b1) begin
            bad++; $display("FAIL bp_accept got=%b want=1", ld_init);
        end
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            hs.in_valid = 1'b0;
        end
        for (int k = 11; k <= 15; k++) begin
            @(negedge clk);
            hs.in_valid = 1'b1; hs.out_ready = 1'b0;
            #1;
            total++;
            if (obs !== {7'b0100001, 4'd10, 8'h36}) begin
                bad++; $display("FAIL bp_hold%0d got=%h want=%h", k, obs,
                                {7'b0100001, 4'd10, 8'h36});
            end
        end
        total++;
        if (m_st !== Cipher) begin
            bad++; $display("FAIL bp_state_stable got=%h want=%h", m_st, Cipher);
        end
        @(negedge clk);
        hs.in_valid = 1'b0; hs.out_ready = 1'b1;
        #1;
        total++;
        if (hs.out_valid !== 1'b1) begin
            bad++; $display("FAIL bp_release_cycle got=%b want=1", hs.out_valid);
        end
        @(negedge clk);
        #1;
        total++;
        if (obs !== {7'b1000000, 4'd0, 8'h01}) begin
            bad++; $display("FAIL bp_back_idle got=%h want=%h", obs, {7'b1000000, 4'd0, 8'h01});
        end
    endtask

    task automatic test_back_to_back;
        int n = 0;
        int last = 0;
        int overlap = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            hs.in_valid = 1'b1; hs.out_ready = 1'b1;
            #1;
            if (ld_init && (busy || st_en || key_en || mix_en)) overlap++;
            if (ld_init) begin
                if (n > 0) begin
                    total++;
                    if (c - last !== 12) begin
                        bad++; $display("FAIL b2b_spacing got=%0d want=12", c - last);
                    end
                end
                last = c;
                n++;
            end
        end
        total++;
        if (n !== 4) begin
            bad++; $display("FAIL b2b_accepts got=%0d want=4", n);
        end
        total++;
        if (overlap !== 0) begin
            bad++; $display("FAIL b2b_overlap got=%0d want=0", overlap);
        end
        @(negedge clk);
        hs.in_valid = 1'b0;
        repeat (12) @(negedge clk);
        #1;
        total++;
        if (obs !== {7'b1000000, 4'd0, 8'h01}) begin
            bad++; $display("FAIL b2b_drain got=%h want=%h", obs, {7'b1000000, 4'd0, 8'h01});
        end
    endtask

    task automatic test_reset_mid;
        int seen = 0;
        @(negedge clk);
        hs.in_valid = 1'b1; hs.out_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            hs.in_valid = 1'b0;
        end
        #1;
        total++;
        if (obs !== {7'b0001111, 4'd5, 8'h10}) begin
            bad++; $display("FAIL mid_round5 got=%h want=%h", obs, {7'b0001111, 4'd5, 8'h10});
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (obs !== {7'b1000000, 4'd0, 8'h01}) begin
            bad++; $display("FAIL mid_reset_idle got=%h want=%h", obs, {7'b1000000, 4'd0, 8'h01});
        end
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            #1;
            if (hs.out_valid) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++; $display("FAIL mid_no_output got=%0d want=0", seen);
        end
    endtask

    task automatic test_nr14;
        logic [18:0] exp;
        @(negedge clk);
        hs14.in_valid = 1'b1; hs14.out_ready = 1'b1;
        #1;
        total++;
        if (obs14 !== {7'b1010000, 4'd0, 8'h01}) begin
            bad++; $display("FAIL nr14_accept got=%h want=%h", obs14, {7'b1010000, 4'd0, 8'h01});
        end
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            hs14.in_valid = 1'b0;
            #1;
            if (k <= 13)      exp = {7'b0001111, 4'(k), rc_tab[k]};
            else if (k == 14) exp = {7'b0001101, 4'd14, 8'h4d};
            else if (k == 15) exp = {7'b0100001, 4'd14, 8'h4d};
            else              exp = {7'b1000000, 4'd0, 8'h01};
            total++;
            if (obs14 !== exp) begin
                bad++; $display("FAIL nr14_cycle%0d got=%h want=%h", k, obs14, exp);
            end
        end
    endtask

    initial begin
        rc_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                   8'h80, 8'h1b, 8'h36, 8'h6c, 8'hd8, 8'hab, 8'h4d};
        pt = '0; key = '0;
        hs.in_valid = 1'b0;   hs.out_ready = 1'b0;
        hs14.in_valid = 1'b0; hs14.out_ready = 1'b0;
        test_reset;
        test_spurious_idle;
        test_single;
        test_backpressure;
        test_back_to_back;
        test_reset_mid;
        test_nr14;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_round_seq.md
Name: aes_round_seq

Overview:
- Control-only sequencer for the iterative AES encryption core.
- Drives the shared round datapath (SubBytes/ShiftRows byte-substitution stage, MixColumns, AddRoundKey, key-expansion step) one round per clock.
- Generates round count, Rcon and per-round enables, and frames the run with a valid/ready handshake on input and output.
- Sits between the block-level input/output buffers and the round datapath registers.

Parameters:
- NR, 10, number of rounds; legal values 10, 12, 14. Any other value is a configuration error; behaviour is undefined.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  plaintext+key presented by upstream
- in_ready  output  1  sequencer can accept a new block
- out_valid  output  1  ciphertext in datapath state register is final
- out_ready  input  1  downstream consumes ciphertext
- ld_init  output  1  datapath loads state <= plaintext ^ key, key_reg <= key
- st_en  output  1  state register updates with round result
- key_en  output  1  key register advances one expansion step
- mix_en  output  1  MixColumns in path (0 = bypass, final round)
- rcon  output  8  round constant for the key-expansion step this cycle
- round_cnt  output  4  current round number (0 when idle)
- busy  output  1  high from accept through end of HOLD

Behaviour:
- Reset (clk edge with rst=1): state IDLE.
  - in_ready=1, out_valid=0, ld_init=st_en=key_en=mix_en=0, rcon=8'h01, round_cnt=0, busy=0.
- Reset overrides everything, including a run in progress. Any partial run is discarded; there is no output for it.
- FSM states:
  - IDLE: in_ready=1. Accept happens when in_valid&in_ready. ld_init=in_valid&in_ready (combinational, same cycle). On accept: next ROUND, round_cnt<=1, rcon<=8'h01.
  - ROUND: st_en=key_en=mix_en=1, busy=1. Each cycle round_cnt<=round_cnt+1 and rcon<=xtime(rcon). When round_cnt==NR-1, next state is LAST.
  - LAST: st_en=key_en=1, mix_en=0. round_cnt=NR. Next state is HOLD.
  - HOLD: out_valid=1, all enables 0, round_cnt holds NR. When out_ready=1, next state is IDLE with round_cnt<=0 and rcon<=8'h01.
- xtime(r) = {r[6:0],1'b0} ^ (r[7] ? 8'h1b : 8'h00).
- Rcon sequence over rounds 1..10: 01,02,04,08,10,20,40,80,1b,36.
  - For NR>10 the same recurrence continues (6c, d8, ab, 4d). The key-expansion datapath decides which rounds consume rcon.
- Latency: accept at cycle T → out_valid at T+NR+1.
- in_ready=0 in ROUND, LAST and HOLD. Exactly one block is in flight; there is no overlap.
- in_valid during ROUND, LAST or HOLD is ignored and not latched. Upstream must hold it.
- out_valid stays high and outputs stay stable while out_ready=0. There is no timeout.
- out_ready while not in HOLD is ignored.
- HOLD→IDLE costs one cycle. A new accept is possible at the earliest one cycle after the out handshake, so throughput is one block per NR+2 cycles with out_ready tied high.
- Enables never overlap with ld_init. st_en and key_en are always equal.

Test Plan:
- Reset then single block, NR=10, out_ready=1: in_valid at T → ld_init=1 at T; mix_en=1 for T+1..T+9; mix_en=0/st_en=1 at T+10; out_valid=1 at T+11; rcon per cycle 01..36 as listed. Feed the FIPS-197 vector (pt 00112233..ff, key 000102..0f) through the full core → ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD → out_valid stays 1, in_ready stays 0, round_cnt=10 and enables 0 throughout; release → IDLE next cycle, in_ready=1.
- Back-to-back: in_valid held high, out_ready=1 → accepts spaced exactly 12 cycles apart; no second ld_init while busy.
- Reset mid-run: assert rst in ROUND with round_cnt=5 → next cycle IDLE, round_cnt=0, rcon=01, out_valid never asserted for that run.
- NR=14 build: round_cnt reaches 14 in LAST, out_valid at T+15, rcon at round 14 = 8'h4d.
- Spurious out_ready in IDLE/ROUND and in_valid in HOLD → no state change, no extra handshakes.
